button_event_ctrl: RTL and testbench

Multi-button front-end controller turning N raw push-button inputs into a queue of classified press events (short/long) for the rest of the design. Each channel synchronizes, debounces and edge-classifies its button. A round-robin arbiter then shares one event FIFO between all channels, and a downstream consumer drains the FIFO with a valid/ready handshake.

---
 rtl/button_pkg.sv | 24 ++
 rtl/button_channel.sv | 89 ++++++++
 rtl/button_event_ctrl.sv | 129 ++++++++++++
 tb/tb_button_event_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types for the button event controller: channel FSM states, the
// queued event record and a counter-width helper.
package button_pkg;

  // Widest id the controller supports (N_BTN up to 16).
  localparam int ID_MAX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic                is_long;
  } btn_event_t;

  // Bits needed to index/count n values, never less than one.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchronizer, debouncer and short/long press classifier.
// emit/emitLong are single-cycle strobes; deb is the debounced level.
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000
) (
  input  logic clk,
  input  logic rstN,
  input  logic btn,
  output logic emit,
  output logic emitLong,
  output logic deb
);

  localparam int DB_W   = clog2_min1(DEBOUNCE_CYCLES);
  localparam int HOLD_W = clog2_min1(LONG_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   deb_q, deb_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  btn_state_e             state_q, state_d;
  logic                   sync_lvl;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], btn};
    sync_lvl = sync_q[SYNC_STAGES-1];
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (sync_lvl != deb_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) deb_d = ~deb_q;
      else                                        db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // IDLE only ever sees deb high on the cycle after a rise, so a level test suffices.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    emit     = 1'b0;
    emitLong = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (deb_q) begin
          state_d = ST_PRESSED;
          hold_d  = '0;
        end
      end
      ST_PRESSED: begin
        if (!deb_q) begin
          emit    = 1'b1;
          state_d = ST_IDLE;
        end else if (hold_q == HOLD_W'(LONG_CYCLES - 1)) begin
          emit     = 1'b1;
          emitLong = 1'b1;
          state_d  = ST_HELD;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_HELD: begin
        if (!deb_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      deb_q    <= 1'b0;
      hold_q   <= '0;
      state_q  <= ST_IDLE;
    end else begin
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
      deb_q    <= deb_d;
      hold_q   <= hold_d;
      state_q  <= state_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/button_event_ctrl.sv
// N-button front end: per-channel classifiers feed pending flags, a
// round-robin arbiter moves them into a shared event FIFO.
module button_event_ctrl
  import button_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic [N_BTN-1:0]         btnIn,
  input  logic                     evReady,
  output logic                     evValid,
  output logic [$clog2(N_BTN)-1:0] evId,
  output logic                     evLong,
  output logic                     evDrop,
  output logic [N_BTN-1:0]         btnLevel
);

  localparam int ID_W  = $clog2(N_BTN);
  localparam int IW1   = ID_W + 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [N_BTN-1:0] emit, emit_long;
  logic [N_BTN-1:0] pend_q, pend_d, pend_long_q, pend_long_d, drop;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d, grant_id;
  logic             grant_vld;
  logic [IW1-1:0]   idx;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop, full;
  btn_event_t       mem_q [FIFO_DEPTH];
  btn_event_t       new_ev, head;
  logic             unused_head_id;

  button_channel #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .LONG_CYCLES    (LONG_CYCLES)
  ) u_ch [N_BTN-1:0] (
    .clk     (clk),
    .rstN    (rstN),
    .btn     (btnIn),
    .emit    (emit),
    .emitLong(emit_long),
    .deb     (btnLevel)
  );

  // Fullness is taken before this cycle's pop; blocked events wait in pending.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    if (!full) begin
      for (int i = 0; i < N_BTN; i++) begin
        idx = {1'b0, rr_ptr_q} + IW1'(i);
        if (idx >= IW1'(N_BTN)) idx = idx - IW1'(N_BTN);
        if (!grant_vld && pend_q[idx[ID_W-1:0]]) begin
          grant_vld = 1'b1;
          grant_id  = idx[ID_W-1:0];
        end
      end
    end
  end

  // A same-cycle grant frees the slot, so the new emit is kept rather than dropped.
  always_comb begin
    pend_d      = pend_q;
    pend_long_d = pend_long_q;
    drop        = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (grant_vld && grant_id == ID_W'(i)) pend_d[i] = 1'b0;
      if (emit[i]) begin
        if (pend_q[i] && !(grant_vld && grant_id == ID_W'(i))) begin
          drop[i] = 1'b1;
        end else begin
          pend_d[i]      = 1'b1;
          pend_long_d[i] = emit_long[i];
        end
      end
    end
  end

  assign push = grant_vld;
  assign pop  = evValid && evReady;
  assign full = (cnt_q == CNT_W'(FIFO_DEPTH));

  always_comb begin
    new_ev.id      = ID_MAX_W'(grant_id);
    new_ev.is_long = pend_long_q[grant_id];
    wr_ptr_d       = wr_ptr_q + PTR_W'(push);
    rd_ptr_d       = rd_ptr_q + PTR_W'(pop);
    cnt_d          = cnt_q + CNT_W'(push) - CNT_W'(pop);
    rr_ptr_d       = rr_ptr_q;
    if (grant_vld) rr_ptr_d = (grant_id == ID_W'(N_BTN - 1)) ? '0 : grant_id + ID_W'(1);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pend_q      <= '0;
      pend_long_q <= '0;
      rr_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pend_q      <= pend_d;
      pend_long_q <= pend_long_d;
      rr_ptr_q    <= rr_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      if (push) mem_q[wr_ptr_q] <= new_ev;
    end
  end

  assign head           = mem_q[rd_ptr_q];
  assign evValid        = (cnt_q != '0);
  assign evId           = head.id[ID_W-1:0];
  assign evLong         = head.is_long;
  assign evDrop         = |drop;
  assign unused_head_id = ^head.id;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: expected events are queued as
// buttons are driven and compared as the consumer accepts them.
module tb_button_event_ctrl;

  localparam int N   = 4;
  localparam int DB  = 4;
  localparam int LNG = 20;

  logic         clk = 1'b0;
  logic         rstN;
  logic [N-1:0] btnIn;
  logic         evReady;
  logic         evValid;
  logic [1:0]   evId;
  logic         evLong;
  logic         evDrop;
  logic [N-1:0] btnLevel;

  typedef struct { int id; int lng; } exp_t;
  exp_t exp_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int ev_seen     = 0;
  int drop_cnt    = 0;
  int deb0_rises  = 0;
  logic deb0_prev = 1'b0;

  button_event_ctrl #(
    .N_BTN(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES(LNG), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rstN(rstN), .btnIn(btnIn), .evReady(evReady),
    .evValid(evValid), .evId(evId), .evLong(evLong), .evDrop(evDrop),
    .btnLevel(btnLevel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Consumer side of the scoreboard.
  always @(negedge clk) begin
    if (rstN && evValid && evReady) begin
      ev_seen++;
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ev_id", 32'(evId), e.id);
        chk("ev_long", 32'(evLong), e.lng);
      end
    end
    if (rstN && evDrop) drop_cnt++;
    if (btnLevel[0] && !deb0_prev) deb0_rises++;
    deb0_prev = btnLevel[0];
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int id, input int lng);
    exp_t e;
    e.id  = id;
    e.lng = lng;
    exp_q.push_back(e);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!evValid && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  task automatic wait_level(input int b, output int n);
    n = 0;
    while (!btnLevel[b] && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    exp_q.delete();
    tick(2);
    rstN = 1'b1;
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, s0, d0, r0;
    rstN    = 1'b0;
    btnIn   = '0;
    evReady = 1'b1;
    tick(3);
    chk("rst_evValid", 32'(evValid), 0);
    chk("rst_evId", 32'(evId), 0);
    chk("rst_evLong", 32'(evLong), 0);
    chk("rst_evDrop", 32'(evDrop), 0);
    chk("rst_btnLevel", 32'(btnLevel), 0);
    rstN = 1'b1;
    tick(2);

    // Short press on btn1
    btnIn[1] = 1'b1;
    tick(10);
    btnIn[1] = 1'b0;
    expect_ev(1, 0);
    wait_valid(n);
    chk("short_latency", n, 2 + DB + 2);
    tick(10);
    chk("short_sb_empty", exp_q.size(), 0);

    // Long press on btn2, 60 cycles
    btnIn[2] = 1'b1;
    expect_ev(2, 1);
    wait_level(2, n);
    chk("deb_rise_latency", n, 2 + DB);
    wait_valid(s0);
    chk("long_latency", s0, LNG + 2);
    tick(60 - n - s0);
    btnIn[2] = 1'b0;
    tick(20);
    chk("long_sb_empty", exp_q.size(), 0);
    chk("long_level_low", 32'(btnLevel[2]), 0);

    // Bounce on btn0, then a clean short press
    r0 = deb0_rises;
    for (int i = 0; i < 15; i++) begin
      btnIn[0] = ~btnIn[0];
      tick(2);
    end
    tick(10);
    btnIn[0] = 1'b0;
    expect_ev(0, 0);
    tick(20);
    chk("bounce_deb_rises", deb0_rises - r0, 1);
    chk("bounce_sb_empty", exp_q.size(), 0);

    // Simultaneous releases from a fresh pointer
    do_reset();
    d0 = drop_cnt;
    btnIn = 4'hF;
    tick(10);
    btnIn = 4'h0;
    for (int i = 0; i < 4; i++) expect_ev(i, 0);
    tick(25);
    chk("simul4_sb_empty", exp_q.size(), 0);
    btnIn = 4'b1001;
    tick(10);
    btnIn = 4'h0;
    expect_ev(0, 0);
    expect_ev(3, 0);
    tick(25);
    chk("simul2_sb_empty", exp_q.size(), 0);
    chk("simul_no_drop", drop_cnt - d0, 0);

    // Backpressure: fill FIFO, one pending, one dropped
    evReady = 1'b0;
    d0 = drop_cnt;
    s0 = ev_seen;
    btnIn = 4'hF;
    tick(10);
    btnIn = 4'h0;
    for (int i = 0; i < 4; i++) expect_ev(i, 0);
    tick(15);
    btnIn[1] = 1'b1;
    tick(10);
    btnIn[1] = 1'b0;
    expect_ev(1, 0);
    tick(15);
    chk("bp_no_drop_yet", drop_cnt - d0, 0);
    btnIn[1] = 1'b1;
    tick(10);
    btnIn[1] = 1'b0;
    tick(15);
    chk("bp_drop_pulse", drop_cnt - d0, 1);
    chk("bp_valid_held", 32'(evValid), 1);
    chk("bp_head_id", 32'(evId), 0);
    chk("bp_head_long", 32'(evLong), 0);
    evReady = 1'b1;
    tick(20);
    chk("bp_drained", ev_seen - s0, 5);
    chk("bp_sb_empty", exp_q.size(), 0);

    // Reset while btn3 held with two entries queued
    evReady = 1'b0;
    btnIn = 4'b0011;
    tick(10);
    btnIn = 4'b1000;
    tick(15);
    chk("prerst_valid", 32'(evValid), 1);
    chk("prerst_level3", 32'(btnLevel[3]), 1);
    rstN = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_async_valid", 32'(evValid), 0);
    chk("rst_async_level", 32'(btnLevel), 0);
    tick(3);
    rstN = 1'b1;
    evReady = 1'b1;
    expect_ev(3, 1);
    wait_valid(n);
    chk("rst_long_latency", n, 2 + DB + LNG + 2);
    tick(10);
    btnIn = 4'h0;
    tick(20);
    chk("rst_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
